// File: rtl/fifo_uart_tx.sv
// UART 8N1 transmitter with optional even parity, draining an upstream 8-bit FIFO.
// The FIFO is read with a one-cycle strobe issued from IDLE. The returned byte is
// captured in LOAD and then sent LSB-first as start, data, [parity], stop bits.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       tx_en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rdata,
    output logic       fifo_ren,
    output logic       tx,
    output logic       busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            par_q, par_d;
    logic            tx_q, tx_d;
    logic            baud_last;

    assign baud_last = (baud_q == BAUD_MAX);
    assign tx        = tx_q;
    assign busy      = (state_q != IDLE);

    // Read strobe is combinational so the FIFO sees it in the same cycle the FSM decides to start.
    always_comb begin
        fifo_ren = nrst && (state_q == IDLE) && tx_en && !fifo_empty;
    end

    // Next-state and datapath logic for the frame sequencer.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        tx_d    = tx_q;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (fifo_ren) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // Data returned by the FIFO is only valid in this cycle.
                shreg_d = fifo_rdata;
                par_d   = ^fifo_rdata;
                tx_d    = 1'b0;
                baud_d  = '0;
                state_d = START;
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        if (PARITY_EN) begin
                            tx_d    = par_q;
                            state_d = PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            PARITY: begin
                if (baud_last) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any frame in flight and parks the line high.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: channel 0 runs without parity, channel 1 with even parity.
// Each channel has a small FIFO model. A frame-level model predicts ren, busy and tx
// every cycle, and directed checks pin literal timings.
module tb_fifo_uart_tx;

    localparam int C = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic       nrst;
    logic       tx_en0, tx_en1;
    logic       empty0, empty1;
    logic [7:0] rdata0 = 8'h00;
    logic [7:0] rdata1 = 8'h00;
    logic       ren0, ren1, tx0, tx1, busy0, busy1;

    // Upstream FIFO models: registered read, data valid the cycle after the strobe.
    logic [7:0] mem0 [16];
    logic [7:0] mem1 [16];
    int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;

    assign empty0 = (wr0 == rd0);
    assign empty1 = (wr1 == rd1);

    always @(posedge clk) begin
        if (ren0) begin
            rdata0 <= mem0[rd0 % 16];
            rd0    <= rd0 + 1;
        end
        if (ren1) begin
            rdata1 <= mem1[rd1 % 16];
            rd1    <= rd1 + 1;
        end
    end

    fifo_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b0)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .tx_en      (tx_en0),
        .fifo_empty (empty0),
        .fifo_rdata (rdata0),
        .fifo_ren   (ren0),
        .tx         (tx0),
        .busy       (busy0)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1)) dut_p (
        .clk        (clk),
        .nrst       (nrst),
        .tx_en      (tx_en1),
        .fifo_empty (empty1),
        .fifo_rdata (rdata1),
        .fifo_ren   (ren1),
        .tx         (tx1),
        .busy       (busy1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // Frame model: line level at offset d from the strobe cycle.
    bit         act_m [2];
    int         t0_m  [2];
    logic [7:0] b_m   [2];

    function automatic logic exp_tx(input int d, input logic [7:0] b, input int p);
        int s;
        if (d < 2) return 1'b1;
        s = (d - 2) / C;
        if (s == 0) return 1'b0;
        if (s <= 8) return b[s-1];
        if (p == 1 && s == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic model_step(input int k, input logic r, input logic bz, input logic t,
                              input logic en, input logic emp, input logic [7:0] front);
        int  f;
        int  d;
        bit  live;
        logic er;
        f = (10 + k) * C;
        if (!nrst) begin
            check($sformatf("m%0d_rst_tx", k), t, 1'b1);
            check($sformatf("m%0d_rst_busy", k), bz, 1'b0);
            check($sformatf("m%0d_rst_ren", k), r, 1'b0);
            act_m[k] = 1'b0;
            return;
        end
        d    = cyc - t0_m[k];
        live = act_m[k] && d >= 1 && d <= f + 1;
        er   = !live && en && !emp;
        check($sformatf("m%0d_ren", k), r, er);
        check($sformatf("m%0d_busy", k), bz, live);
        check($sformatf("m%0d_tx", k), t, live ? exp_tx(d, b_m[k], k) : 1'b1);
        if (er) begin
            act_m[k] = 1'b1;
            t0_m[k]  = cyc;
            b_m[k]   = front;
        end
    endtask

    always @(negedge clk) begin
        model_step(0, ren0, busy0, tx0, tx_en0, empty0, mem0[rd0 % 16]);
        model_step(1, ren1, busy1, tx1, tx_en1, empty1, mem1[rd1 % 16]);
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_cyc(input int t);
        do @(negedge clk); while (cyc < t);
    endtask

    task automatic push(input int k, input logic [7:0] b);
        if (k == 0) begin
            mem0[wr0 % 16] = b;
            wr0++;
        end else begin
            mem1[wr1 % 16] = b;
            wr1++;
        end
    endtask

    task automatic wait_ren(input int k, output int t0);
        int n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        do begin
            @(negedge clk);
            n++;
            seen = (k == 0) ? ren0 : ren1;
        end while (!seen && n < 200);
        t0 = cyc;
        if (!seen) check($sformatf("ren%0d_timeout", k), 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2;
        for (int i = 0; i < 2; i++) begin
            act_m[i] = 1'b0;
            t0_m[i]  = 0;
            b_m[i]   = 8'h00;
        end
        nrst   = 1'b0;
        tx_en0 = 1'b0;
        tx_en1 = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_tx", tx0, 1'b1);
        check("reset_busy", busy0, 1'b0);
        check("reset_ren", ren0, 1'b0);
        sync();
        nrst = 1'b1;

        // 1: single byte 0xA5, bits 1,0,1,0,0,1,0,1
        sync();
        push(0, 8'hA5);
        tx_en0 = 1'b1;
        wait_ren(0, t0);
        goto_cyc(t0 + 1);  check("t1_ren_one_cycle", ren0, 1'b0);
                           check("t1_busy_load", busy0, 1'b1);
                           check("t1_tx_load", tx0, 1'b1);
        goto_cyc(t0 + 2);  check("t1_start_first", tx0, 1'b0);
        goto_cyc(t0 + 5);  check("t1_start_last", tx0, 1'b0);
        goto_cyc(t0 + 6);  check("t1_bit0", tx0, 1'b1);
        goto_cyc(t0 + 10); check("t1_bit1", tx0, 1'b0);
        goto_cyc(t0 + 34); check("t1_bit7", tx0, 1'b1);
        goto_cyc(t0 + 38); check("t1_stop", tx0, 1'b1);
        goto_cyc(t0 + 41); check("t1_busy_end", busy0, 1'b1);
        goto_cyc(t0 + 42); check("t1_busy_fall", busy0, 1'b0);

        // 2: back-to-back 0x00 then 0xFF
        sync();
        push(0, 8'h00);
        push(0, 8'hFF);
        wait_ren(0, t0);
        goto_cyc(t0 + 6);  check("t2_bit0_zero", tx0, 1'b0);
        goto_cyc(t0 + 38); check("t2_stop", tx0, 1'b1);
        goto_cyc(t0 + 42); check("t2_second_ren", ren0, 1'b1);
                           check("t2_gap_idle", tx0, 1'b1);
        goto_cyc(t0 + 43); check("t2_gap_load", tx0, 1'b1);
        goto_cyc(t0 + 44); check("t2_second_start", tx0, 1'b0);
        goto_cyc(t0 + 50); check("t2_ff_bit0", tx0, 1'b1);
        goto_cyc(t0 + 85); check("t2_done", busy0, 1'b0);

        // 3: parity channel, 0x07 -> parity 1, 0x03 -> parity 0
        sync();
        push(1, 8'h07);
        push(1, 8'h03);
        tx_en1 = 1'b1;
        wait_ren(1, t0);
        goto_cyc(t0 + 38); check("t3_parity_07", tx1, 1'b1);
        goto_cyc(t0 + 42); check("t3_stop", tx1, 1'b1);
        goto_cyc(t0 + 45); check("t3_busy_end", busy1, 1'b1);
        goto_cyc(t0 + 46); check("t3_busy_fall", busy1, 1'b0);
                           check("t3_second_ren", ren1, 1'b1);
        goto_cyc(t0 + 46 + 38); check("t3_parity_03", tx1, 1'b0);
        goto_cyc(t0 + 46 + 46); check("t3_done", busy1, 1'b0);
        sync();
        tx_en1 = 1'b0;

        // 4: tx_en low holds off; dropping it mid-frame lets the frame finish
        sync();
        tx_en0 = 1'b0;
        push(0, 8'h5A);
        goto_cyc(cyc + 20);
        check("t4_no_ren", ren0, 1'b0);
        check("t4_line_idle", tx0, 1'b1);
        check("t4_not_busy", busy0, 1'b0);
        sync();
        tx_en0 = 1'b1;
        wait_ren(0, t0);
        goto_cyc(t0 + 9);
        sync();
        tx_en0 = 1'b0;
        push(0, 8'hC3);
        goto_cyc(t0 + 38); check("t4_stop_reached", tx0, 1'b1);
        goto_cyc(t0 + 41); check("t4_frame_completes", busy0, 1'b1);
        goto_cyc(t0 + 60); check("t4_no_second_ren", ren0, 1'b0);
                           check("t4_idle_after", busy0, 1'b0);

        // 5: reset mid-data on 0xC3 (bit3 = 0 on the line at t0+20)
        sync();
        push(0, 8'h96);
        tx_en0 = 1'b1;
        wait_ren(0, t0);
        goto_cyc(t0 + 19);
        sync();
        check("t5_pre_reset_bit3", tx0, 1'b0);
        nrst = 1'b0;
        #1;
        check("t5_reset_tx", tx0, 1'b1);
        check("t5_reset_busy", busy0, 1'b0);
        sync();
        sync();
        nrst = 1'b1;
        wait_ren(0, t1);
        goto_cyc(t1 + 6);  check("t5_next_bit0", tx0, 1'b0);
        goto_cyc(t1 + 10); check("t5_next_bit1", tx0, 1'b1);
        goto_cyc(t1 + 18); check("t5_next_bit3", tx0, 1'b0);
        goto_cyc(t1 + 42); check("t5_next_done", busy0, 1'b0);

        // 6: three queued bytes go out in order, then nothing more
        sync();
        push(0, 8'h11);
        push(0, 8'h22);
        push(0, 8'h33);
        wait_ren(0, t0);
        wait_ren(0, t1);
        wait_ren(0, t2);
        check("t6_gap1", t1 - t0, 42);
        check("t6_gap2", t2 - t1, 42);
        goto_cyc(t2 + 100);
        check("t6_no_fourth_ren", ren0, 1'b0);
        check("t6_idle_busy", busy0, 1'b0);
        check("t6_idle_tx", tx0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
